pb_event_decoder: RTL and testbench

Converts the debounced push-button level into discrete one-cycle user events: press, release, long-press and auto-repeat. It sits directly downstream of the push-button debounce stage and reads its clean level output. It drives the control FSMs and counters in the lab top level, so no downstream block performs its own edge detection or hold timing.

---
 rtl/pb_event_pkg.sv | 19 +
 rtl/pb_hold_timer.sv | 29 ++
 rtl/pb_event_decoder.sv | 132 +++++++++++++
 tb/tb_pb_event_decoder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pb_event_pkg.sv
// Shared types and default timing constants for the push-button event decoder.
package pb_event_pkg;

   // Decoder FSM states, with an explicit encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_LONG  = 2'd2
   } pb_state_t;

   localparam int DEF_LONG_PRESS_CYCLES = 100;
   localparam int DEF_REPEAT_CYCLES     = 20;

   // Larger of two ints. Used to size the shared hold counter.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pb_hold_timer.sv
// Clearable up-counter with a run-time terminal value. The decoder uses one
// instance for both the long-press hold and the auto-repeat period.
module pb_hold_timer #(
   parameter int CNT_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [CNT_WIDTH-1:0] term_value,
   output logic                 terminal
);

   logic [CNT_WIDTH-1:0] count;

   // Count register: clear wins over enable, so the count never wraps.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + 1'b1;
   end

   assign terminal = (count == term_value);

endmodule

// File: rtl/pb_event_decoder.sv
// Push-button event decoder: turns the debounced level into one-cycle press,
// release, long-press and auto-repeat pulses, plus a held level.
// Auto-repeat is built only when the macro PB_EVENT_REPEAT_EN is defined;
// otherwise repeat_pulse is tied to 0 and LONG holds the counter at 0.
module pb_event_decoder
   import pb_event_pkg::*;
#(
   parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
   parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES,
   parameter int CNT_WIDTH         = $clog2(max_int(LONG_PRESS_CYCLES, REPEAT_CYCLES))
) (
   input  logic clk,
   input  logic rst,
   input  logic pb_debounced,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press_pulse,
   output logic repeat_pulse,
   output logic held
);

   localparam logic [CNT_WIDTH-1:0] LONG_TERM = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);

   pb_state_t            state_q, state_d;
   logic                 cnt_clear, cnt_enable, cnt_terminal;
   logic [CNT_WIDTH-1:0] term_value;
   logic                 press_d, release_d, long_d;

`ifdef PB_EVENT_REPEAT_EN
   localparam logic [CNT_WIDTH-1:0] REPEAT_TERM = CNT_WIDTH'(REPEAT_CYCLES - 1);
   logic repeat_d;
   logic repeat_q;

   // The single counter times the hold in PRESS and the repeat period in LONG.
   assign term_value   = (state_q == ST_LONG) ? REPEAT_TERM : LONG_TERM;
   assign repeat_pulse = repeat_q;
`else
   assign term_value   = LONG_TERM;
   assign repeat_pulse = 1'b0;
`endif

   pb_hold_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .clear      (cnt_clear),
      .enable     (cnt_enable),
      .term_value (term_value),
      .terminal   (cnt_terminal)
   );

   // Next-state and next-output logic; release outranks any terminal count.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_d    = state_q;
      cnt_clear  = 1'b0;
      cnt_enable = 1'b0;
      press_d    = 1'b0;
      release_d  = 1'b0;
      long_d     = 1'b0;
`ifdef PB_EVENT_REPEAT_EN
      repeat_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_clear = 1'b1;
            if (pb_debounced) begin
               state_d = ST_PRESS;
               press_d = 1'b1;
            end
         end
         ST_PRESS: begin
            if (!pb_debounced) begin
               state_d   = ST_IDLE;
               release_d = 1'b1;
               cnt_clear = 1'b1;
            end else if (cnt_terminal) begin
               state_d   = ST_LONG;
               long_d    = 1'b1;
               cnt_clear = 1'b1;
            end else begin
               cnt_enable = 1'b1;
            end
         end
         ST_LONG: begin
            if (!pb_debounced) begin
               state_d   = ST_IDLE;
               release_d = 1'b1;
               cnt_clear = 1'b1;
            end else begin
`ifdef PB_EVENT_REPEAT_EN
               if (cnt_terminal) begin
                  repeat_d  = 1'b1;
                  cnt_clear = 1'b1;
               end else begin
                  cnt_enable = 1'b1;
               end
`else
               cnt_clear = 1'b1;
`endif
            end
         end
         default: begin
            state_d   = ST_IDLE;
            cnt_clear = 1'b1;
         end
      endcase
   end

   // State and registered outputs; reset silences every pulse on its edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         press_pulse      <= 1'b0;
         release_pulse    <= 1'b0;
         long_press_pulse <= 1'b0;
         held             <= 1'b0;
`ifdef PB_EVENT_REPEAT_EN
         repeat_q         <= 1'b0;
`endif
      end else begin
         state_q          <= state_d;
         press_pulse      <= press_d;
         release_pulse    <= release_d;
         long_press_pulse <= long_d;
         held             <= (state_d == ST_LONG);
`ifdef PB_EVENT_REPEAT_EN
         repeat_q         <= repeat_d;
`endif
      end
   end

endmodule

// File: tb/tb_pb_event_decoder.sv
// Self-checking bench for pb_event_decoder with LONG_PRESS_CYCLES=8,
// REPEAT_CYCLES=3. Expected outputs come from a hold-time reference model,
// queued when stimulus is driven and compared after the following edge.
module tb_pb_event_decoder;

   localparam int LP = 8;
   localparam int RP = 3;
`ifdef PB_EVENT_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   typedef struct packed {
      logic press;
      logic rel;
      logic lng;
      logic rep;
      logic hld;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   logic pb_debounced;
   logic press_pulse, release_pulse, long_press_pulse, repeat_pulse, held;

   int checks   = 0;
   int failures = 0;

   ev_t exp_q[$];

   // Reference model state: pressed flag and edges since the accepted press.
   bit m_pressed = 1'b0;
   int m_hold    = 0;

   pb_event_decoder #(
      .LONG_PRESS_CYCLES (LP),
      .REPEAT_CYCLES     (RP)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .pb_debounced     (pb_debounced),
      .press_pulse      (press_pulse),
      .release_pulse    (release_pulse),
      .long_press_pulse (long_press_pulse),
      .repeat_pulse     (repeat_pulse),
      .held             (held)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got press/rel/long/rep/held=%b expected %b at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Expected outputs after an edge that samples pb_v / rst_v.
   function automatic ev_t model_edge(input logic pb_v, input logic rst_v);
      ev_t e;
      e = '0;
      if (rst_v) begin
         m_pressed = 1'b0;
         m_hold    = 0;
      end else if (!m_pressed) begin
         if (pb_v) begin
            m_pressed = 1'b1;
            m_hold    = 0;
            e.press   = 1'b1;
         end
      end else if (!pb_v) begin
         m_pressed = 1'b0;
         e.rel     = 1'b1;
      end else begin
         m_hold++;
         e.lng = (m_hold == LP);
         e.rep = REP_EN && (m_hold > LP) && ((m_hold - LP) % RP == 0);
         e.hld = (m_hold >= LP);
      end
      return e;
   endfunction

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic step(input logic pb_v, input logic rst_v, input string tag);
      ev_t obs;
      ev_t exp_e;
      @(negedge clk);
      pb_debounced = pb_v;
      rst          = rst_v;
      exp_q.push_back(model_edge(pb_v, rst_v));
      @(posedge clk);
      #1;
      obs = '{press_pulse, release_pulse, long_press_pulse, repeat_pulse, held};
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         exp_e = exp_q.pop_front();
         check(tag, obs, exp_e);
      end
   endtask

   task automatic run(input logic pb_v, input int n, input string tag);
      for (int i = 0; i < n; i++) step(pb_v, 1'b0, tag);
   endtask

   initial begin
      rst          = 1'b1;
      pb_debounced = 1'b0;

      // Reset state, with the button held through reset.
      step(1'b0, 1'b1, "reset");
      step(1'b1, 1'b1, "reset_held");
      run(1'b1, 3, "press_after_reset");
      run(1'b0, 2, "idle");

      // Single-cycle press.
      run(1'b1, 1, "short_press");
      run(1'b0, 3, "short_release");

      // 20-cycle hold: long at k+8, repeats at k+11/14/17, release at k+20.
      run(1'b1, 20, "hold20");
      run(1'b0, 3, "hold20_release");

      // Release exactly at the long-press terminal count.
      run(1'b1, 8, "term_hold");
      run(1'b0, 3, "term_release");

      // Reset mid-press with the button still high.
      run(1'b1, 5, "pre_reset");
      step(1'b1, 1'b1, "mid_reset");
      run(1'b1, 10, "post_reset");
      run(1'b0, 2, "post_reset_rel");

      // Release then immediate re-press; the hold count restarts.
      run(1'b1, 2, "repress_a");
      run(1'b0, 1, "repress_gap");
      run(1'b1, 14, "repress_b");
      run(1'b0, 2, "repress_rel");

      // Random hold bursts.
      for (int b = 0; b < 8; b++) begin
         run(1'b1, int'($urandom_range(1, 20)), "rand_hold");
         run(1'b0, int'($urandom_range(1, 4)), "rand_gap");
      end

      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
